// File: rtl/sensor_emu_ctl_axi_mc_if.sv
// AXI4-Lite bus bundle (32-bit address and data) for the sensor emulator control block.
interface sensor_emu_ctl_axi_mc_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );
endinterface

// File: rtl/sensor_emu_ctl_axi_mc.sv
// Multi-channel sensor emulator control/status block terminating an AXI4-Lite slave directly.
// Per-channel self-timed FIFO reset sequencers with timeout; load words gated by backpressure.
module sensor_emu_ctl_axi_mc #(
  parameter int unsigned CHANNELS      = 4,
  parameter logic [31:0] MODULE_REV    = 32'h0000_0002,
  parameter int unsigned RESET_TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  sensor_emu_ctl_axi_mc_if.slave   s_axi,
  output logic [CHANNELS-1:0]      fifo_reset_o,
  input  logic [CHANNELS-1:0]      reset_busy_i,
  output logic [63:0]              load_data_o,
  output logic [CHANNELS-1:0]      load_valid_o,
  input  logic [CHANNELS-1:0]      load_ready_i,
  output logic [2:0]               start_chan_o,
  output logic                     start_wstrobe_o,
  output logic                     hard_stop_wstrobe_o,
  input  logic [32*CHANNELS-1:0]   count_i,
  input  logic [2:0]               active_chan_i,
  input  logic                     running_i
);

  localparam logic [1:0]  RespOkay    = 2'b00;
  localparam logic [1:0]  RespSlvErr  = 2'b10;
  localparam logic [1:0]  RespDecErr  = 2'b11;
  localparam logic [15:0] TimeoutLast = 16'(RESET_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAssert, StRelease} seq_state_e;

  // Write channel state
  logic                live_q;
  logic                aw_have_q, w_have_q;
  logic [5:0]          awword_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  // Read channel state
  logic                rvalid_q;
  logic [31:0]         rdata_q;
  logic [1:0]          rresp_q;
  // Register file and strobes
  logic [31:0]         upper_q, upper_d;
  logic [63:0]         load_data_q;
  logic [CHANNELS-1:0] load_valid_q;
  logic [2:0]          start_chan_q;
  logic                start_q, stop_q;
  logic [CHANNELS-1:0] fifo_start_q;
  logic [CHANNELS-1:0] timeout_q, timeout_d;
  // Sequencers
  seq_state_e          seq_q [CHANNELS];
  seq_state_e          seq_d [CHANNELS];
  logic [15:0]         cnt_q [CHANNELS];
  logic [15:0]         cnt_d [CHANNELS];
  logic [CHANNELS-1:0] to_set;
  logic [CHANNELS-1:0] seq_busy;

  logic        aw_hs, w_hs, ar_hs, do_write;
  logic [5:0]  wr_word, wr_idx, rd_word, rd_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_chan_ok, rd_chan_ok;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data;
  logic [7:0]  load_hit8, fifo_req8, clr8, ready8;
  logic        start_hit, stop_hit;
  logic [255:0] count_pad;
  logic [31:0] status;

  assign s_axi.awready = live_q & ~aw_have_q & ~bvalid_q;
  assign s_axi.wready  = live_q & ~w_have_q & ~bvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = live_q & ~rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign aw_hs = s_axi.awvalid & s_axi.awready;
  assign w_hs  = s_axi.wvalid & s_axi.wready;
  assign ar_hs = s_axi.arvalid & s_axi.arready;

  // A write executes on the edge that completes the second of the AW/W captures.
  assign do_write = (aw_have_q | aw_hs) & (w_have_q | w_hs);
  assign wr_word  = aw_have_q ? awword_q : s_axi.awaddr[7:2];
  assign wr_data  = w_have_q ? wdata_q : s_axi.wdata;
  assign wr_strb  = w_have_q ? wstrb_q : s_axi.wstrb;

  // Channel windows start at word 8 with LOAD on even and COUNT on odd words.
  assign wr_idx     = wr_word - 6'd8;
  assign wr_chan_ok = (wr_word >= 6'd8) && (wr_idx[5:1] < 5'(CHANNELS));
  assign rd_word    = s_axi.araddr[7:2];
  assign rd_idx     = rd_word - 6'd8;
  assign rd_chan_ok = (rd_word >= 6'd8) && (rd_idx[5:1] < 5'(CHANNELS));

  assign ready8    = 8'(load_ready_i);
  assign count_pad = 256'(count_i);

  always_comb begin
    wr_resp   = RespSlvErr;
    upper_d   = upper_q;
    load_hit8 = '0;
    fifo_req8 = '0;
    clr8      = '0;
    start_hit = 1'b0;
    stop_hit  = 1'b0;
    if (do_write) begin
      case (wr_word)
        6'h03: begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) upper_d[8*b +: 8] = wr_data[8*b +: 8];
          end
          wr_resp = RespOkay;
        end
        6'h04: begin
          fifo_req8 = wr_data[7:0];
          wr_resp   = RespOkay;
        end
        6'h05: begin
          start_hit = 1'b1;
          wr_resp   = RespOkay;
        end
        6'h06: begin
          stop_hit = 1'b1;
          wr_resp  = RespOkay;
        end
        6'h07: begin
          clr8    = wr_data[15:8];
          wr_resp = RespOkay;
        end
        default: begin
          if (wr_chan_ok && !wr_idx[0] && ready8[wr_idx[3:1]]) begin
            load_hit8 = 8'b1 << wr_idx[3:1];
            wr_resp   = RespOkay;
          end
        end
      endcase
    end
  end

  // Timeout set takes priority over a same-cycle clear.
  assign timeout_d = (timeout_q & ~clr8[CHANNELS-1:0]) | to_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q       <= 1'b0;
      aw_have_q    <= 1'b0;
      w_have_q     <= 1'b0;
      awword_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RespOkay;
      upper_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= '0;
      start_chan_q <= '0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      fifo_start_q <= '0;
      timeout_q    <= '0;
    end else begin
      live_q <= 1'b1;
      if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
      if (do_write) begin
        aw_have_q <= 1'b0;
        w_have_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_resp;
      end else begin
        if (aw_hs) begin
          aw_have_q <= 1'b1;
          awword_q  <= s_axi.awaddr[7:2];
        end
        if (w_hs) begin
          w_have_q <= 1'b1;
          wdata_q  <= s_axi.wdata;
          wstrb_q  <= s_axi.wstrb;
        end
      end
      upper_q      <= upper_d;
      load_valid_q <= load_hit8[CHANNELS-1:0];
      start_q      <= start_hit;
      stop_q       <= stop_hit;
      if (start_hit) start_chan_q <= wr_data[2:0];
      if (|load_hit8) load_data_q <= {upper_q, wr_data};
      fifo_start_q <= fifo_req8[CHANNELS-1:0];
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    status = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      status[c]     = seq_busy[c];
      status[8 + c] = timeout_q[c];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RespDecErr;
    case (rd_word)
      6'h00: begin
        rd_data = MODULE_REV;
        rd_resp = RespOkay;
      end
      6'h01: begin
        rd_data = status;
        rd_resp = RespOkay;
      end
      6'h02: begin
        rd_data = {running_i, 28'b0, active_chan_i};
        rd_resp = RespOkay;
      end
      6'h03: begin
        rd_data = upper_q;
        rd_resp = RespOkay;
      end
      default: begin
        if (rd_chan_ok && rd_idx[0]) begin
          rd_data = count_pad[{rd_idx[3:1], 5'b0} +: 32];
          rd_resp = RespOkay;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Reset sequencers: state register, next-state logic, outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        seq_q[c] <= StIdle;
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        seq_q[c] <= seq_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  always_comb begin
    to_set = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      seq_d[c] = seq_q[c];
      cnt_d[c] = cnt_q[c];
      case (seq_q[c])
        StIdle: begin
          if (fifo_start_q[c]) begin
            seq_d[c] = StAssert;
            cnt_d[c] = '0;
          end
        end
        StAssert: begin
          if (reset_busy_i[c]) begin
            seq_d[c] = StRelease;
            cnt_d[c] = '0;
          end else if (cnt_q[c] == TimeoutLast) begin
            seq_d[c]  = StIdle;
            to_set[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + 16'd1;
          end
        end
        StRelease: begin
          if (!reset_busy_i[c]) begin
            seq_d[c] = StIdle;
          end else if (cnt_q[c] == TimeoutLast) begin
            seq_d[c]  = StIdle;
            to_set[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + 16'd1;
          end
        end
        default: seq_d[c] = StIdle;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      fifo_reset_o[c] = (seq_q[c] == StAssert);
      seq_busy[c]     = (seq_q[c] != StIdle);
    end
  end

  assign load_data_o         = load_data_q;
  assign load_valid_o        = load_valid_q;
  assign start_chan_o        = start_chan_q;
  assign start_wstrobe_o     = start_q;
  assign hard_stop_wstrobe_o = stop_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awaddr[31:8], s_axi.awaddr[1:0], s_axi.awprot,
                       s_axi.araddr[31:8], s_axi.araddr[1:0], s_axi.arprot};

endmodule
